// File: rtl/exec_issue_ctrl_pkg.sv
// Shared definitions for the issue controller: execute unit selects, FSM states and sizing.
// The alu_sel codes are also decoded by the execute stage, so keep them stable.
package exec_issue_ctrl_pkg;

    localparam int NUM_TAGS     = 16;
    localparam int TAG_W        = $clog2(NUM_TAGS);
    localparam int MAX_INFLIGHT = 8;
    localparam int NUM_REGS     = 32;
    localparam int REG_W        = $clog2(NUM_REGS);
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [2:0] {
        ADDER   = 3'd0,
        LOGICAL = 3'd1,
        SHIFTER = 3'd2,
        BRANCH  = 3'd3,
        MEMORY  = 3'd4,
        BYPASS  = 3'd5
    } alu_sel_e;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/exec_issue_ctrl_if.sv
// Decoded-op handshake between operand fetch (master) and the issue controller (slave).
interface exec_issue_ctrl_if;
    import exec_issue_ctrl_pkg::*;

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       alu_sel;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;

    modport master (
        output op_valid, alu_sel, rd, wr_en, rs1, rs2, rs1_used, rs2_used,
        input  op_ready
    );

    modport slave (
        input  op_valid, alu_sel, rd, wr_en, rs1, rs2, rs1_used, rs2_used,
        output op_ready
    );

endinterface

// File: rtl/exec_issue_ctrl_tag_table.sv
// Tag pool: per-tag busy/rd/we bookkeeping, round-robin allocation head and in-flight count.
module exec_tag_table
    import exec_issue_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alloc,
    input  logic [REG_W-1:0] i_alloc_rd,
    input  logic             i_alloc_we,
    input  logic             i_ret_valid,
    input  logic [TAG_W-1:0] i_ret_tag,
    output logic [TAG_W-1:0] o_head,
    output logic             o_head_busy,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ret_hit,
    output logic [REG_W-1:0] o_ret_rd,
    output logic             o_ret_we
);

    logic [NUM_TAGS-1:0] r_tagBusy;
    logic [NUM_TAGS-1:0] r_weTab;
    logic [REG_W-1:0]    r_rdTab [NUM_TAGS];
    logic [TAG_W-1:0]    r_head;
    logic [CNT_W-1:0]    r_count;
    logic                w_retHit;
    logic [TAG_W-1:0]    w_headNext;

    // A retire naming a tag that is not busy is stale and must not touch the count.
    assign w_retHit    = i_ret_valid & r_tagBusy[i_ret_tag];
    assign w_headNext  = (r_head == TAG_W'(NUM_TAGS - 1)) ? '0 : r_head + TAG_W'(1);

    assign o_head      = r_head;
    assign o_head_busy = r_tagBusy[r_head];
    assign o_full      = (r_count >= CNT_W'(MAX_INFLIGHT));
    assign o_count     = r_count;
    assign o_ret_hit   = w_retHit;
    assign o_ret_rd    = r_rdTab[i_ret_tag];
    assign o_ret_we    = r_weTab[i_ret_tag];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tagBusy <= '0;
            r_weTab   <= '0;
            r_head    <= '0;
            r_count   <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_rdTab[i] <= '0;
            end
        end else begin
            if (w_retHit) begin
                r_tagBusy[i_ret_tag] <= 1'b0;
            end
            if (i_alloc) begin
                r_tagBusy[r_head] <= 1'b1;
                r_rdTab[r_head]   <= i_alloc_rd;
                r_weTab[r_head]   <= i_alloc_we;
                r_head            <= w_headNext;
            end
            if (i_alloc && !w_retHit) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_alloc && w_retHit) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue scheduler: RAW scoreboard, memory serialisation and branch-wait/flush FSM
// in front of the tag table.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    exec_issue_ctrl_if.slave   op_bus,
    output logic               o_issue,
    output logic [TAG_W-1:0]   o_tag,
    input  logic               i_ret_valid,
    input  logic [TAG_W-1:0]   i_ret_tag,
    input  logic               i_br_resolve,
    input  logic               i_jump,
    input  logic               i_mem_done,
    output logic               o_flush,
    output logic [3:0]         o_inflight
);

    state_e            r_state;
    logic              r_issue;
    logic [TAG_W-1:0]  r_tag;
    logic              r_flush;
    logic              r_memBusy;
    logic [CNT_W-1:0]  r_wrCnt [NUM_REGS];

    logic [TAG_W-1:0]  w_head;
    logic              w_headBusy;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic              w_retHit;
    logic [REG_W-1:0]  w_retRd;
    logic              w_retWe;
    logic              w_raw;
    logic              w_ready;
    logic              w_accept;
    logic              w_isMem;
    logic              w_isBranch;
    logic [NUM_REGS-1:0] w_incVec;
    logic [NUM_REGS-1:0] w_decVec;

    exec_tag_table u_tag_table (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_alloc     (w_accept),
        .i_alloc_rd  (op_bus.rd),
        .i_alloc_we  (op_bus.wr_en),
        .i_ret_valid (i_ret_valid),
        .i_ret_tag   (i_ret_tag),
        .o_head      (w_head),
        .o_head_busy (w_headBusy),
        .o_full      (w_full),
        .o_count     (w_count),
        .o_ret_hit   (w_retHit),
        .o_ret_rd    (w_retRd),
        .o_ret_we    (w_retWe)
    );

    // Hazard check reads registered writer counts only, so a retire unblocks the next cycle.
    assign w_raw      = (op_bus.rs1_used && (r_wrCnt[op_bus.rs1] != '0))
                      | (op_bus.rs2_used && (r_wrCnt[op_bus.rs2] != '0));
    assign w_isMem    = (op_bus.alu_sel == MEMORY);
    assign w_isBranch = (op_bus.alu_sel == BRANCH);
    assign w_ready    = (r_state == S_RUN) & ~w_headBusy & ~w_full & ~w_raw
                      & ~(r_memBusy & w_isMem);
    assign w_accept   = op_bus.op_valid & w_ready;

    assign op_bus.op_ready = w_ready;
    assign o_issue    = r_issue;
    assign o_tag      = r_tag;
    assign o_flush    = r_flush;
    assign o_inflight = w_count;

    always_comb begin
        w_incVec = '0;
        w_decVec = '0;
        if (w_accept && op_bus.wr_en && (op_bus.rd != '0)) begin
            w_incVec[op_bus.rd] = 1'b1;
        end
        if (w_retHit && w_retWe && (w_retRd != '0)) begin
            w_decVec[w_retRd] = 1'b1;
        end
    end

    // Per-register writer count: a register stays pending while any in-flight op writes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wrCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_incVec[i] && !w_decVec[i]) begin
                    r_wrCnt[i] <= r_wrCnt[i] + CNT_W'(1);
                end else if (w_decVec[i] && !w_incVec[i]) begin
                    r_wrCnt[i] <= r_wrCnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_RUN;
            r_issue   <= 1'b0;
            r_tag     <= '0;
            r_flush   <= 1'b0;
            r_memBusy <= 1'b0;
        end else begin
            r_issue <= w_accept;
            r_flush <= 1'b0;
            if (w_accept) begin
                r_tag <= w_head;
            end
            if (w_accept && w_isMem) begin
                r_memBusy <= 1'b1;
            end else if (i_mem_done) begin
                r_memBusy <= 1'b0;
            end
            case (r_state)
                S_RUN: begin
                    if (w_accept && w_isBranch) begin
                        r_state <= S_BR_WAIT;
                    end
                end
                S_BR_WAIT: begin
                    if (i_br_resolve) begin
                        if (i_jump) begin
                            r_state <= S_FLUSH;
                            r_flush <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle against
// a tag-set reference model of the issue controller.
module tb_exec_issue_ctrl;
    import exec_issue_ctrl_pkg::*;

    logic             clk;
    logic             rst;
    logic             issue;
    logic [TAG_W-1:0] tag;
    logic             retValid;
    logic [TAG_W-1:0] retTag;
    logic             brResolve;
    logic             jump;
    logic             memDone;
    logic             flush;
    logic [3:0]       inflight;

    int compared   = 0;
    int mismatched = 0;

    bit mBusy [NUM_TAGS];
    int mRd   [NUM_TAGS];
    bit mWe   [NUM_TAGS];
    int mHead;
    bit mMemBusy;
    bit mBrWait;
    bit mFlushing;
    bit mIssue;
    int mTag;

    exec_issue_ctrl_if opIf ();

    exec_issue_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .op_bus       (opIf),
        .o_issue      (issue),
        .o_tag        (tag),
        .i_ret_valid  (retValid),
        .i_ret_tag    (retTag),
        .i_br_resolve (brResolve),
        .i_jump       (jump),
        .i_mem_done   (memDone),
        .o_flush      (flush),
        .o_inflight   (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int inflightCount();
        int n = 0;
        foreach (mBusy[t]) if (mBusy[t]) n++;
        return n;
    endfunction

    // A register is pending while any busy tag is recorded as writing it; x0 never is.
    function automatic bit regPending(int r);
        if (r == 0) return 1'b0;
        foreach (mBusy[t]) if (mBusy[t] && mWe[t] && mRd[t] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelReady();
        bit raw;
        raw = (opIf.rs1_used && regPending(int'(opIf.rs1)))
           || (opIf.rs2_used && regPending(int'(opIf.rs2)));
        return !mBrWait && !mFlushing && !mBusy[mHead] && (inflightCount() < MAX_INFLIGHT)
            && !raw && !(mMemBusy && opIf.alu_sel == MEMORY);
    endfunction

    function automatic void resetModel();
        foreach (mBusy[t]) begin
            mBusy[t] = 1'b0;
            mRd[t]   = 0;
            mWe[t]   = 1'b0;
        end
        mHead     = 0;
        mMemBusy  = 1'b0;
        mBrWait   = 1'b0;
        mFlushing = 1'b0;
        mIssue    = 1'b0;
        mTag      = 0;
    endfunction

    task automatic checkOutput(input string name, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input alu_sel_e sel, input int rd, input bit we,
                                 input int rs1, input bit u1, input int rs2, input bit u2);
        opIf.op_valid = v;
        opIf.alu_sel  = sel;
        opIf.rd       = REG_W'(rd);
        opIf.wr_en    = we;
        opIf.rs1      = REG_W'(rs1);
        opIf.rs1_used = u1;
        opIf.rs2      = REG_W'(rs2);
        opIf.rs2_used = u2;
    endtask

    task automatic setSide(input bit rv, input int rt, input bit br, input bit jmp, input bit md);
        retValid  = rv;
        retTag    = TAG_W'(rt);
        brResolve = br;
        jump      = jmp;
        memDone   = md;
    endtask

    // One clock: check ready mid-cycle, advance the model on the edge, check registered outputs.
    task automatic step();
        bit       expReady;
        bit       accept;
        alu_sel_e cSel;
        int       cRd;
        bit       cWe;
        bit       cRet;
        int       cRetTag;
        bit       cBr;
        bit       cJump;
        bit       cMemDone;
        bit       nextFlush;
        #1;
        expReady = modelReady();
        checkOutput("op_ready", int'(opIf.op_ready), int'(expReady));
        accept   = opIf.op_valid && expReady;
        cSel     = alu_sel_e'(opIf.alu_sel);
        cRd      = int'(opIf.rd);
        cWe      = opIf.wr_en;
        cRet     = retValid;
        cRetTag  = int'(retTag);
        cBr      = brResolve;
        cJump    = jump;
        cMemDone = memDone;
        @(posedge clk);
        if (cRet && mBusy[cRetTag]) mBusy[cRetTag] = 1'b0;
        nextFlush = mBrWait && cBr && cJump;
        if (mBrWait) mBrWait = !cBr;
        else         mBrWait = accept && (cSel == BRANCH);
        mFlushing = nextFlush;
        if (accept && cSel == MEMORY) mMemBusy = 1'b1;
        else if (cMemDone)            mMemBusy = 1'b0;
        mIssue = accept;
        if (accept) begin
            mTag         = mHead;
            mBusy[mHead] = 1'b1;
            mRd[mHead]   = cRd;
            mWe[mHead]   = cWe;
            mHead        = (mHead + 1) % NUM_TAGS;
        end
        #1;
        checkOutput("issue", int'(issue), int'(mIssue));
        checkOutput("tag", int'(tag), mTag);
        checkOutput("flush", int'(flush), int'(nextFlush));
        checkOutput("inflight", int'(inflight), inflightCount());
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        resetModel();
        checkOutput("rst_issue", int'(issue), 0);
        checkOutput("rst_tag", int'(tag), 0);
        checkOutput("rst_flush", int'(flush), 0);
        checkOutput("rst_inflight", int'(inflight), 0);
        checkOutput("rst_ready", int'(opIf.op_ready), int'(modelReady()));
        #2;
        rst = 1'b0;
    endtask

    task automatic randomCycle();
        int busyTags[$];
        foreach (mBusy[t]) if (mBusy[t]) busyTags.push_back(t);
        applyStimulus(($urandom_range(0, 3) != 0), alu_sel_e'($urandom_range(0, 5)),
                      $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        retValid = ($urandom_range(0, 2) == 0);
        if (busyTags.size() > 0 && $urandom_range(0, 3) != 0)
            retTag = TAG_W'(busyTags[$urandom_range(0, busyTags.size() - 1)]);
        else
            retTag = TAG_W'($urandom_range(0, NUM_TAGS - 1));
        brResolve = mBrWait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        jump      = 1'($urandom_range(0, 1));
        memDone   = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, ADDER, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        #6;
        doReset();

        $display("[TB] back-to-back independent adds");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ADDER, i + 1, 1'b1, 0, 1'b0, 0, 1'b0);
            step();
            checkOutput("t1_issue", int'(issue), 1);
            checkOutput("t1_tag", int'(tag), i);
        end

        $display("[TB] RAW stall released by retire");
        doReset();
        applyStimulus(1'b1, ADDER, 5, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t2_tag0", int'(tag), 0);
        applyStimulus(1'b1, ADDER, 6, 1'b1, 5, 1'b1, 0, 1'b0);
        step();
        checkOutput("t2_stall0", int'(issue), 0);
        step();
        checkOutput("t2_stall1", int'(issue), 0);
        setSide(1'b1, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t2_retire_cycle", int'(issue), 0);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t2_issue", int'(issue), 1);
        checkOutput("t2_tag1", int'(tag), 1);

        $display("[TB] taken branch and flush");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ADDER, 10 + i, 1'b1, 0, 1'b0, 0, 1'b0);
            step();
        end
        applyStimulus(1'b1, BRANCH, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t3_br_tag", int'(tag), 3);
        applyStimulus(1'b1, ADDER, 20, 1'b1, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t3_hold", int'(issue), 0);
        end
        setSide(1'b0, 0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("t3_flush", int'(flush), 1);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t3_flush_end", int'(flush), 0);
        checkOutput("t3_flush_noissue", int'(issue), 0);
        step();
        checkOutput("t3_resume", int'(issue), 1);
        checkOutput("t3_resume_tag", int'(tag), 4);

        $display("[TB] memory serialisation");
        doReset();
        applyStimulus(1'b1, MEMORY, 1, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t4_load", int'(issue), 1);
        applyStimulus(1'b1, MEMORY, 2, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t4_mem_stall", int'(issue), 0);
        applyStimulus(1'b1, ADDER, 3, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t4_add", int'(issue), 1);
        checkOutput("t4_add_tag", int'(tag), 1);
        applyStimulus(1'b1, MEMORY, 2, 1'b1, 0, 1'b0, 0, 1'b0);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("t4_done_cycle", int'(issue), 0);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t4_mem2", int'(issue), 1);
        checkOutput("t4_mem2_tag", int'(tag), 2);

        $display("[TB] in-flight limit");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, ADDER, i + 1, 1'b1, 0, 1'b0, 0, 1'b0);
            step();
            checkOutput("t5_fill_tag", int'(tag), i);
        end
        applyStimulus(1'b1, ADDER, 20, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        checkOutput("t5_full_noissue", int'(issue), 0);
        checkOutput("t5_full_count", int'(inflight), 8);
        setSide(1'b1, 4, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t5_retire_cycle", int'(issue), 0);
        checkOutput("t5_after_retire", int'(inflight), 7);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t5_resume", int'(issue), 1);
        checkOutput("t5_resume_tag", int'(tag), 8);

        $display("[TB] reset during branch wait");
        doReset();
        applyStimulus(1'b1, ADDER, 7, 1'b1, 0, 1'b0, 0, 1'b0);
        step();
        applyStimulus(1'b1, BRANCH, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        step();
        applyStimulus(1'b1, ADDER, 8, 1'b1, 7, 1'b1, 0, 1'b0);
        step();
        checkOutput("t6_wait", int'(issue), 0);
        doReset();
        #1;
        checkOutput("t6_ready", int'(opIf.op_ready), 1);
        step();
        checkOutput("t6_issue", int'(issue), 1);
        checkOutput("t6_tag", int'(tag), 0);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                doReset();
            end
            randomCycle();
            step();
        end

        applyStimulus(1'b0, ADDER, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        setSide(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
